// File: rtl/rssb_core.sv
// rssb_core: self-sequencing RSSB (reverse-subtract, skip-if-borrow) engine with internal word memory.
// Optional output port enabled by defining RSSB_OUT_EN.
module rssb_core #(
    parameter int BW       = 8,
    parameter int AW       = 4,
    parameter int OUT_ADDR = (1 << AW) - 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          start,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [BW-1:0] ld_data,
    output logic          busy,
    output logic          halted,
    output logic          flag,
    output logic [BW-1:0] acc,
    output logic [AW-1:0] pc,
    output logic          out_valid,
    output logic [BW-1:0] out_data
);

    localparam int DEPTH = 1 << AW;
`ifdef RSSB_OUT_EN
    localparam bit OUT_EN = 1'b1;
`else
    localparam bit OUT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_READ, S_EXEC, S_HALT} state_t;

    state_t        r_state;
    logic [BW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_ir;
    logic [BW-1:0] r_acc;
    logic [BW-1:0] r_opnd;
    logic          r_flag;
    logic          r_busy;
    logic          r_halted;
    logic          r_out_valid;
    logic [BW-1:0] r_out_data;

    // Subtract at BW+1 bits so the top bit is the borrow.
    logic [BW:0]   w_sub;
    logic          w_borrow;
    logic [BW-1:0] w_diff;
    logic [AW-1:0] w_pc_next;

    assign w_sub     = {1'b0, r_opnd} - {1'b0, r_acc};
    assign w_borrow  = w_sub[BW];
    assign w_diff    = w_sub[BW-1:0];
    assign w_pc_next = r_pc + (w_borrow ? AW'(2) : AW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_ir        <= '0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_flag      <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (ena) begin
                case (r_state)
                    S_IDLE, S_HALT: begin
                        if (ld_we) r_mem[ld_addr] <= ld_data;
                        if (start) begin
                            r_pc     <= '0;
                            r_acc    <= '0;
                            r_flag   <= 1'b0;
                            r_busy   <= 1'b1;
                            r_halted <= 1'b0;
                            r_state  <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        r_ir    <= r_mem[r_pc][AW-1:0];
                        r_state <= S_READ;
                    end
                    S_READ: begin
                        // All-ones operand address is the halt marker.
                        if (&r_ir) begin
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_opnd  <= r_mem[r_ir];
                            r_state <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        r_mem[r_ir] <= w_diff;
                        r_acc       <= w_diff;
                        r_flag      <= w_borrow;
                        r_pc        <= w_pc_next;
                        r_state     <= S_FETCH;
                        if (OUT_EN && (r_ir == AW'(OUT_ADDR))) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_diff;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign halted    = r_halted;
    assign flag      = r_flag;
    assign acc       = r_acc;
    assign pc        = r_pc;
    assign out_valid = r_out_valid & ena;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_rssb_core.sv
// Directed self-checking bench for rssb_core (BW=8, AW=4).
module tb_rssb_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic       ld_we = 1'b0;
    logic [3:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic       busy, halted, flag, out_valid;
    logic [7:0] acc, out_data;
    logic [3:0] pc;

    int tests = 0;
    int fails = 0;

    rssb_core #(.BW(8), .AW(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy), .halted(halted), .flag(flag), .acc(acc), .pc(pc),
        .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; ena = 1'b1; start = 1'b0; ld_we = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic ld(input logic [3:0] a, input logic [7:0] d);
        ld_addr = a; ld_data = d; ld_we = 1'b1;
        step();
        ld_we = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_halt(output int n);
        n = 0;
        while (!halted && n < 60) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        ld(4'd0, 8'd5); ld(4'd1, 8'd15); ld(4'd5, 8'h33);
        kick(); step(); step();
        rst = 1'b0;
        #2;
        tests++; if (acc !== 8'd0)   begin fails++; $display("FAIL rst_acc got %0h want 0", acc); end
        tests++; if (pc !== 4'd0)    begin fails++; $display("FAIL rst_pc got %0h want 0", pc); end
        tests++; if (flag !== 1'b0)  begin fails++; $display("FAIL rst_flag got %0b want 0", flag); end
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL rst_busy got %0b want 0", busy); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL rst_halted got %0b want 0", halted); end
        tests++; if (out_valid !== 1'b0 || out_data !== 8'd0)
            begin fails++; $display("FAIL rst_out got %0b/%0h want 0/0", out_valid, out_data); end
        step();
        rst = 1'b1;
        ld(4'd0, 8'd5); ld(4'd1, 8'd15);
        kick();
        run_to_halt(n);
        tests++; if (acc !== 8'd0 || pc !== 4'd1 || halted !== 1'b1)
            begin fails++; $display("FAIL rst_readback acc=%0h pc=%0h halted=%0b want 0/1/1", acc, pc, halted); end
    endtask

    task automatic test_simple();
        int n;
        do_reset();
        ld(4'd0, 8'd5); ld(4'd1, 8'd15); ld(4'd5, 8'd10);
        kick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL simple_busy got %0b want 1", busy); end
        run_to_halt(n);
        tests++; if (n !== 5) begin fails++; $display("FAIL simple_cycles got %0d want 5", n); end
        tests++; if (acc !== 8'd10 || flag !== 1'b0 || pc !== 4'd1)
            begin fails++; $display("FAIL simple_result acc=%0h flag=%0b pc=%0h want a/0/1", acc, flag, pc); end
        tests++; if (halted !== 1'b1 || busy !== 1'b0)
            begin fails++; $display("FAIL simple_halt halted=%0b busy=%0b want 1/0", halted, busy); end
        kick();
        run_to_halt(n);
        tests++; if (acc !== 8'd10 || n !== 5)
            begin fails++; $display("FAIL simple_rerun acc=%0h n=%0d want a/5", acc, n); end
    endtask

    task automatic test_borrow();
        int n;
        do_reset();
        ld(4'd0, 8'd5); ld(4'd1, 8'd6); ld(4'd2, 8'd15); ld(4'd3, 8'd15);
        ld(4'd5, 8'd10); ld(4'd6, 8'd3);
        kick();
        step(); step(); step();
        tests++; if (acc !== 8'd10 || pc !== 4'd1 || flag !== 1'b0)
            begin fails++; $display("FAIL borrow_first acc=%0h pc=%0h flag=%0b want a/1/0", acc, pc, flag); end
        step(); step(); step();
        tests++; if (acc !== 8'hF9 || pc !== 4'd3 || flag !== 1'b1)
            begin fails++; $display("FAIL borrow_second acc=%0h pc=%0h flag=%0b want f9/3/1", acc, pc, flag); end
        run_to_halt(n);
        tests++; if (n !== 2 || halted !== 1'b1 || pc !== 4'd3)
            begin fails++; $display("FAIL borrow_halt n=%0d halted=%0b pc=%0h want 2/1/3", n, halted, pc); end
        kick();
        run_to_halt(n);
        tests++; if (acc !== 8'hEF || pc !== 4'd2 || flag !== 1'b0)
            begin fails++; $display("FAIL borrow_mem6 acc=%0h pc=%0h flag=%0b want ef/2/0", acc, pc, flag); end
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        ld(4'd0, 8'd5); ld(4'd1, 8'd15); ld(4'd5, 8'd10);
        kick(); step(); step();
        ena = 1'b0;
        repeat (4) step();
        tests++; if (acc !== 8'd0 || pc !== 4'd0 || busy !== 1'b1 || halted !== 1'b0 || out_valid !== 1'b0)
            begin fails++; $display("FAIL stall_frozen acc=%0h pc=%0h busy=%0b halted=%0b", acc, pc, busy, halted); end
        ena = 1'b1;
        run_to_halt(n);
        tests++; if (n !== 3) begin fails++; $display("FAIL stall_cycles got %0d want 3", n); end
        tests++; if (acc !== 8'd10 || pc !== 4'd1 || flag !== 1'b0)
            begin fails++; $display("FAIL stall_result acc=%0h pc=%0h flag=%0b want a/1/0", acc, pc, flag); end
    endtask

    task automatic test_busy_guard();
        int n;
        do_reset();
        ld(4'd0, 8'd5); ld(4'd1, 8'd15); ld(4'd5, 8'd10);
        kick();
        ld_addr = 4'd5; ld_data = 8'h77; ld_we = 1'b1; start = 1'b1;
        step();
        ld_we = 1'b0; start = 1'b0;
        run_to_halt(n);
        tests++; if (n !== 4) begin fails++; $display("FAIL guard_cycles got %0d want 4", n); end
        tests++; if (acc !== 8'd10 || pc !== 4'd1)
            begin fails++; $display("FAIL guard_result acc=%0h pc=%0h want a/1", acc, pc); end
    endtask

    task automatic test_out_port();
        int n;
        int pulses;
        logic [7:0] od;
        do_reset();
        ld(4'd0, 8'd14); ld(4'd1, 8'd15);
        ld_addr = 4'd14; ld_data = 8'h20; ld_we = 1'b1; start = 1'b1;
        step();
        ld_we = 1'b0; start = 1'b0;
        n = 0; pulses = 0; od = '0;
        while (!halted && n < 60) begin
            step();
            n++;
            if (out_valid) begin pulses++; od = out_data; end
        end
        tests++; if (acc !== 8'h20 || n !== 5)
            begin fails++; $display("FAIL out_acc acc=%0h n=%0d want 20/5", acc, n); end
`ifdef RSSB_OUT_EN
        tests++; if (pulses !== 1 || od !== 8'h20)
            begin fails++; $display("FAIL out_pulse pulses=%0d data=%0h want 1/20", pulses, od); end
        tests++; if (out_data !== 8'h20)
            begin fails++; $display("FAIL out_hold got %0h want 20", out_data); end
`else
        tests++; if (pulses !== 0 || out_data !== 8'd0)
            begin fails++; $display("FAIL out_tied pulses=%0d data=%0h want 0/0", pulses, out_data); end
`endif
    endtask

    initial begin
        test_reset();
        test_simple();
        test_borrow();
        test_stall();
        test_busy_guard();
        test_out_port();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
